// File: rtl/jtbubl_pal_pkg.sv
// Shared definitions for the palette RAM port controller: FSM encoding,
// colour channel bit ranges inside a 16-bit entry, byte lane indices.
package jtbubl_pal_pkg;

    typedef enum logic [2:0] {
        ST_CLR  = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD   = 3'd2,
        ST_WT   = 3'd3,
        ST_WR   = 3'd4
    } pal_state_e;

    localparam int R_MSB = 7;
    localparam int R_LSB = 4;
    localparam int G_MSB = 3;
    localparam int G_LSB = 0;
    localparam int B_MSB = 15;
    localparam int B_LSB = 12;

    localparam int LANE_EVEN = 0;
    localparam int LANE_ODD  = 1;

    // Brightness scale of one 4-bit channel: (c * (lvl+1)) >> 4 on a 9-bit product.
    function automatic logic [3:0] scale_nib(input logic [3:0] c, input logic [3:0] lvl);
        logic [8:0] prod;
        prod = {5'd0, c} * ({5'd0, lvl} + 9'd1);
        return prod[7:4];
    endfunction

endpackage

// File: rtl/jtbubl_pal_ctrl_if.sv
// CPU-side palette bus: master is the CPU decode logic, slave is the controller.
interface jtbubl_pal_ctrl_if #(
    parameter int AW = 8
) ();
    logic          cpu_cs;
    logic          cpu_rnw;
    logic [AW:0]   cpu_addr;
    logic [7:0]    cpu_dout;
    logic [7:0]    cpu_din;
    logic          cpu_wait;

    modport master (
        output cpu_cs, cpu_rnw, cpu_addr, cpu_dout,
        input  cpu_din, cpu_wait
    );

    modport slave (
        input  cpu_cs, cpu_rnw, cpu_addr, cpu_dout,
        output cpu_din, cpu_wait
    );
endinterface

// File: rtl/jtbubl_pal_scale.sv
// Combinational fade of one palette entry: R/G/B nibbles scaled by the
// brightness level, bits [11:8] passed through.
module jtbubl_pal_scale
    import jtbubl_pal_pkg::*;
(
    input  logic [15:0] entry,
    input  logic [3:0]  lvl,
    output logic [15:0] scaled
);

    // Scale each colour channel; everything else is copied.
    always_comb begin
        scaled                = entry;
        scaled[R_MSB:R_LSB]   = scale_nib(entry[R_MSB:R_LSB], lvl);
        scaled[G_MSB:G_LSB]   = scale_nib(entry[G_MSB:G_LSB], lvl);
        scaled[B_MSB:B_LSB]   = scale_nib(entry[B_MSB:B_LSB], lvl);
    end

endmodule

// File: rtl/jtbubl_pal_ctrl.sv
// Palette RAM write/read port owner: power-on clear, CPU byte accesses and a
// read-modify-write fade engine, all sharing one registered RAM port.
module jtbubl_pal_ctrl
    import jtbubl_pal_pkg::*;
#(
    parameter int          AW      = 8,
    parameter bit          CLR_EN  = 1'b1,
    parameter logic [15:0] CLR_VAL = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    jtbubl_pal_ctrl_if.slave  cpu,
    output logic [AW-1:0]     ram_addr,
    output logic [15:0]       ram_din,
    output logic [1:0]        ram_we,
    input  logic [15:0]       ram_q,
    input  logic              fade_start,
    input  logic [3:0]        fade_level,
    output logic              fade_busy,
    output logic              fade_done
);

    localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam pal_state_e    ST_RST   = CLR_EN ? ST_CLR : ST_IDLE;

    pal_state_e    state_q,    state_d;
    logic [AW-1:0] idx_q,      idx_d;
    logic [3:0]    lvl_q,      lvl_d;
    logic [15:0]   entry_q,    entry_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]   ram_din_q,  ram_din_d;
    logic [1:0]    ram_we_q,   ram_we_d;
    logic          cpu_wait_q, cpu_wait_d;
    logic [7:0]    cpu_din_q,  cpu_din_d;
    logic          rd_pend_q,  rd_pend_d;
    logic          lane_q,     lane_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;

    logic          cpu_hit_s;
    logic          cpu_wr_idx_s;
    logic [15:0]   scaled_s;

    jtbubl_pal_scale u_scale (
        .entry  (entry_q),
        .lvl    (lvl_q),
        .scaled (scaled_s)
    );

    // Next-state logic: the CPU claims the port first, the FSM fills in the rest.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lvl_d      = lvl_q;
        entry_d    = entry_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 2'b00;
        cpu_wait_d = 1'b0;
        rd_pend_d  = 1'b0;
        lane_d     = lane_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        cpu_hit_s    = cpu.cpu_cs && (state_q != ST_CLR);
        cpu_wr_idx_s = cpu_hit_s && !cpu.cpu_rnw && (cpu.cpu_addr[AW:1] == idx_q);

        if (rd_pend_q) begin
            cpu_din_d = (lane_q == 1'(LANE_ODD)) ? ram_q[15:8] : ram_q[7:0];
        end else begin
            cpu_din_d = cpu_din_q;
        end

        if (cpu_hit_s) begin
            ram_addr_d = cpu.cpu_addr[AW:1];
            if (cpu.cpu_rnw) begin
                rd_pend_d = 1'b1;
                lane_d    = cpu.cpu_addr[0];
            end else begin
                ram_din_d                  = {cpu.cpu_dout, cpu.cpu_dout};
                ram_we_d[cpu.cpu_addr[0]]  = 1'b1;
            end
        end else begin
            ram_addr_d = ram_addr_q;
        end

        case (state_q)
            ST_CLR: begin
                cpu_wait_d = 1'b1;
                ram_addr_d = idx_q;
                ram_din_d  = CLR_VAL;
                ram_we_d   = 2'b11;
                if (idx_q == IDX_LAST) begin
                    idx_d      = IDX_ZERO;
                    state_d    = ST_IDLE;
                    cpu_wait_d = 1'b0;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            ST_IDLE: begin
                if (fade_start) begin
                    lvl_d   = fade_level;
                    idx_d   = IDX_ZERO;
                    busy_d  = 1'b1;
                    state_d = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cpu_hit_s) begin
                    state_d = ST_RD;
                end else begin
                    ram_addr_d = idx_q;
                    state_d    = ST_WT;
                end
            end
            // ram_q is only trusted when no CPU access interleaved with the read.
            ST_WT: begin
                if (cpu_hit_s) begin
                    state_d = ST_RD;
                end else begin
                    entry_d = ram_q;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (cpu_wr_idx_s) begin
                    state_d = ST_RD;
                end else if (cpu_hit_s) begin
                    state_d = ST_WR;
                end else begin
                    ram_addr_d = idx_q;
                    ram_din_d  = scaled_s;
                    ram_we_d   = 2'b11;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = IDX_ZERO;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = ST_RD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RST;
            idx_q      <= IDX_ZERO;
            lvl_q      <= 4'd0;
            entry_q    <= 16'h0000;
            ram_addr_q <= IDX_ZERO;
            ram_din_q  <= 16'h0000;
            ram_we_q   <= 2'b00;
            cpu_wait_q <= CLR_EN;
            cpu_din_q  <= 8'h00;
            rd_pend_q  <= 1'b0;
            lane_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lvl_q      <= lvl_d;
            entry_q    <= entry_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            cpu_wait_q <= cpu_wait_d;
            cpu_din_q  <= cpu_din_d;
            rd_pend_q  <= rd_pend_d;
            lane_q     <= lane_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_din      = ram_din_q;
    assign ram_we       = ram_we_q;
    assign cpu.cpu_din  = cpu_din_q;
    assign cpu.cpu_wait = cpu_wait_q;
    assign fade_busy    = busy_q;
    assign fade_done    = done_q;

endmodule
